// File: rtl/printable_stream_pkg.sv
// Shared types, ASCII constants and hex-digit helper for the printable_stream filter.
// The escape sequencer types are only used when PRINTABLE_STREAM_ESC_EN is defined.
package printable_pkg;

    typedef enum logic [1:0] {
        MODE_REPLACE = 2'd0,
        MODE_DROP    = 2'd1,
        MODE_ESCAPE  = 2'd2
    } mode_e;

    // State names the next character the sequencer loads on advance.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ESC_X  = 2'd1,
        ESC_HI = 2'd2,
        ESC_LO = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_BSLASH = 8'h5C;
    localparam logic [7:0] ASCII_X      = 8'h78;
    localparam logic [7:0] ASCII_HASH   = 8'h23;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        logic [7:0] ext;
        ext = {4'h0, nibble};
        return (nibble < 4'd10) ? (8'h30 + ext) : (8'h37 + ext);
    endfunction

endpackage

// File: rtl/printable_stream_if.sv
// Byte stream with ready/valid handshake; master drives data/valid, slave drives ready.
interface printable_stream_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/printable_stream_classify.sv
// Combinational printable-range classifier; esc additionally marks backslash as non-printable.
module printable_classify
    import printable_pkg::*;
#(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7e
) (
    input  logic [7:0] data,
    input  logic       esc,
    output logic       is_print
);
    assign is_print = (data >= LO) && (data <= HI) && !(esc && (data == ASCII_BSLASH));
endmodule

// File: rtl/printable_stream.sv
// Streaming printable-character filter: replace / drop / hex-escape non-printable bytes.
// ESCAPE mode and its sequencer are compiled in only with PRINTABLE_STREAM_ESC_EN defined.
module printable_stream
    import printable_pkg::*;
#(
    parameter logic [7:0] LO   = 8'h20,
    parameter logic [7:0] HI   = 8'h7e,
    parameter logic [7:0] SUB  = 8'h23,
    parameter int         CNTW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic                clr_cnt,
    output logic [CNTW-1:0]     bad_cnt,
    printable_stream_if.slave   in_s,
    printable_stream_if.master  out_m
);
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [CNTW-1:0] bad_cnt_q, bad_cnt_d;
    logic            in_ready, accept, advance, is_print, esc_sel;

`ifdef PRINTABLE_STREAM_ESC_EN
    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;

    assign esc_sel  = (mode == MODE_ESCAPE);
    // Depends only on registers and out_ready, so no combinational path from in_valid.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_m.ready);
`else
    assign esc_sel  = 1'b0;
    assign in_ready = !out_valid_q || out_m.ready;
`endif

    assign accept  = in_s.valid && in_ready;
    assign advance = out_valid_q && out_m.ready;

    printable_classify #(.LO(LO), .HI(HI)) u_classify (
        .data     (in_s.data),
        .esc      (esc_sel),
        .is_print (is_print)
    );

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !advance;
        bad_cnt_d   = bad_cnt_q;
`ifdef PRINTABLE_STREAM_ESC_EN
        state_d     = state_q;
        hold_d      = hold_q;
`endif
        if (accept) begin
            if (is_print) begin
                out_data_d  = in_s.data;
                out_valid_d = 1'b1;
            end else begin
                case (mode)
                    MODE_DROP: begin
                        out_data_d = out_data_q;
                    end
`ifdef PRINTABLE_STREAM_ESC_EN
                    MODE_ESCAPE: begin
                        out_data_d  = ASCII_BSLASH;
                        out_valid_d = 1'b1;
                        hold_d      = in_s.data;
                        state_d     = ESC_X;
                    end
`endif
                    default: begin
                        out_data_d  = SUB;
                        out_valid_d = 1'b1;
                    end
                endcase
            end
        end
`ifdef PRINTABLE_STREAM_ESC_EN
        // Accept is impossible outside IDLE, so the sequencer never competes with it.
        if (advance) begin
            case (state_q)
                ESC_X: begin
                    out_data_d  = ASCII_X;
                    out_valid_d = 1'b1;
                    state_d     = ESC_HI;
                end
                ESC_HI: begin
                    out_data_d  = hex_ascii(hold_q[7:4]);
                    out_valid_d = 1'b1;
                    state_d     = ESC_LO;
                end
                ESC_LO: begin
                    out_data_d  = hex_ascii(hold_q[3:0]);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = state_d;
                end
            endcase
        end
`endif
        if (clr_cnt) begin
            bad_cnt_d = '0;
        end else if (accept && !is_print && (bad_cnt_q != {CNTW{1'b1}})) begin
            bad_cnt_d = bad_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            bad_cnt_q   <= '0;
`ifdef PRINTABLE_STREAM_ESC_EN
            state_q     <= IDLE;
            hold_q      <= 8'h00;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            bad_cnt_q   <= bad_cnt_d;
`ifdef PRINTABLE_STREAM_ESC_EN
            state_q     <= state_d;
            hold_q      <= hold_d;
`endif
        end
    end

    assign in_s.ready  = in_ready;
    assign out_m.data  = out_data_q;
    assign out_m.valid = out_valid_q;
    assign bad_cnt     = bad_cnt_q;

endmodule
